// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the multi-cycle serial adder.
package serial_adder_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of a counter that must hold values 0..n.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// One-bit combinational full adder; the serial adder ripples a chain of these.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder summing BITS_PER_CYCLE bits per clock with a start/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a - b via inverted b and carry-in 1).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / BITS_PER_CYCLE;
    localparam int CW = count_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    if (WIDTH < 2 || BITS_PER_CYCLE < 1 || (WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_cfg
        $error("serial_adder: BITS_PER_CYCLE must divide WIDTH (WIDTH >= 2)");
    end

    state_t                    state;
    logic [CW-1:0]             count;
    logic [WIDTH-1:0]          opa;
    logic [WIDTH-1:0]          opb;
    logic [WIDTH-1:0]          acc;
    logic                      carry;

    logic [BITS_PER_CYCLE:0]   c;
    logic [BITS_PER_CYCLE-1:0] s;
    logic [WIDTH+BITS_PER_CYCLE-1:0] acc_cat;
    logic [WIDTH-1:0]          acc_nxt;
    logic [WIDTH-1:0]          b_in;
    logic                      carry_in;

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is a + ~b + 1, so the carry-in port is ignored when sub is set.
    assign b_in     = sub ? ~b : b;
    assign carry_in = sub ? 1'b1 : cin;
`else
    assign b_in     = b;
    assign carry_in = cin;
`endif

    assign c[0] = carry;

    for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_chain
        fa_cell u_fa (
            .a    (opa[i]),
            .b    (opb[i]),
            .cin  (c[i]),
            .sum  (s[i]),
            .cout (c[i+1])
        );
    end

    // New chunk enters at the top; after N cycles bit 0 of the result sits at acc[0].
    assign acc_cat = {s, acc};
    assign acc_nxt = acc_cat[WIDTH+BITS_PER_CYCLE-1:BITS_PER_CYCLE];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            opa      <= '0;
            opb      <= '0;
            acc      <= '0;
            carry    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b_in;
                        carry <= carry_in;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    opa   <= opa >> BITS_PER_CYCLE;
                    opb   <= opb >> BITS_PER_CYCLE;
                    acc   <= acc_nxt;
                    carry <= c[BITS_PER_CYCLE];
                    count <= count + CW'(1);
                    // On the final chunk the chain's top cell is bit WIDTH-1.
                    if (count == LAST) begin
                        sum      <= acc_nxt;
                        cout     <= c[BITS_PER_CYCLE];
                        overflow <= c[BITS_PER_CYCLE-1] ^ c[BITS_PER_CYCLE];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: twelve WIDTH/BITS_PER_CYCLE configurations share one stimulus bus.
module tb_serial_adder;

    localparam int NCFG = 12;

    function automatic int cfg_w(input int k);
        if (k < 3) return 4;
        if (k < 7) return 8;
        return 16;
    endfunction

    function automatic int cfg_b(input int k);
        case (k)
            0: return 1;  1: return 2;  2: return 4;
            3: return 1;  4: return 2;  5: return 4;  6: return 8;
            7: return 1;  8: return 2;  9: return 4;  10: return 8;
            default: return 16;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;

    logic [NCFG-1:0]       busy_v;
    logic [NCFG-1:0]       done_v;
    logic [NCFG-1:0]       cout_v;
    logic [NCFG-1:0]       ovf_v;
    logic [NCFG-1:0][15:0] sum_v;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < NCFG; k++) begin : g_dut
        localparam int W  = cfg_w(k);
        localparam int BP = cfg_b(k);
        logic [W-1:0] s;
        serial_adder #(.WIDTH(W), .BITS_PER_CYCLE(BP)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .a        (a[W-1:0]),
            .b        (b[W-1:0]),
            .cin      (cin),
`ifdef SERIAL_ADDER_SUB_EN
            .sub      (sub),
`endif
            .busy     (busy_v[k]),
            .done     (done_v[k]),
            .sum      (s),
            .cout     (cout_v[k]),
            .overflow (ovf_v[k])
        );
        assign sum_v[k] = 16'(s);
    end

    // Reference: plain integer arithmetic on the operands as the spec defines them.
    task automatic model(input int w, input logic [15:0] ai, input logic [15:0] bi,
                         input logic ci, input logic si,
                         output logic [15:0] s, output logic co, output logic ov);
        longint mask, ua, ub, sa, sb, r, hi, lo, tot;
        mask = (longint'(1) << w) - 1;
        ua = longint'(ai) & mask;
        ub = longint'(bi) & mask;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        sa = (ua > hi) ? ua - (mask + 1) : ua;
        sb = (ub > hi) ? ub - (mask + 1) : ub;
        if (si) begin
            tot = ua - ub;
            co  = (ua >= ub);
            r   = sa - sb;
        end else begin
            tot = ua + ub + longint'(ci);
            co  = ((tot >> w) & 1) != 0;
            r   = sa + sb + longint'(ci);
        end
        s  = 16'(tot & mask);
        ov = (r > hi) || (r < lo);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [15:0] ai, input logic [15:0] bi,
                            input logic ci, input logic si);
        a = ai; b = bi; cin = ci; sub = si; start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int k, output int lat);
        lat = -1;
        for (int c = 1; c <= 24; c++) begin
            step();
            if (done_v[k]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        #12;
        asserts++; if (busy_v !== '0) begin fails++; $display("FAIL reset_busy got=%h want=0", busy_v); end
        asserts++; if (done_v !== '0) begin fails++; $display("FAIL reset_done got=%h want=0", done_v); end
        asserts++; if (sum_v !== '0) begin fails++; $display("FAIL reset_sum got=%h want=0", sum_v); end
        asserts++; if ((cout_v | ovf_v) !== '0) begin fails++; $display("FAIL reset_flags cout=%h ovf=%h want=0", cout_v, ovf_v); end
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int lat;
        start_op(16'h005A, 16'h003C, 1'b0, 1'b0);
        asserts++; if (busy_v[3] !== 1'b1) begin fails++; $display("FAIL basic_busy got=%b want=1", busy_v[3]); end
        wait_done(3, lat);
        asserts++; if (lat != 8) begin fails++; $display("FAIL basic_latency got=%0d want=8", lat); end
        asserts++; if ({cout_v[3], ovf_v[3], sum_v[3]} !== {1'b0, 1'b1, 16'h0096})
            begin fails++; $display("FAIL basic_result got=%b/%b/%h want=0/1/0096", cout_v[3], ovf_v[3], sum_v[3]); end
        asserts++; if (busy_v[3] !== 1'b0) begin fails++; $display("FAIL basic_busy_end got=%b want=0", busy_v[3]); end
        step();
        asserts++; if (done_v[3] !== 1'b0) begin fails++; $display("FAIL basic_done_pulse got=%b want=0", done_v[3]); end

        start_op(16'h00FF, 16'h0001, 1'b1, 1'b0);
        wait_done(5, lat);
        asserts++; if (lat != 2) begin fails++; $display("FAIL b4_latency got=%0d want=2", lat); end
        asserts++; if ({cout_v[5], ovf_v[5], sum_v[5]} !== {1'b1, 1'b0, 16'h0001})
            begin fails++; $display("FAIL b4_result got=%b/%b/%h want=1/0/0001", cout_v[5], ovf_v[5], sum_v[5]); end
        repeat (8) step();
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [15:0] a0, b0, a1, b1, es;
        logic c0, c1, ec, eo;
        a0 = 16'($urandom); b0 = 16'($urandom); c0 = 1'($urandom);
        a1 = 16'($urandom); b1 = 16'($urandom); c1 = 1'($urandom);
        pulse_reset();
        a = a0; b = b0; cin = c0; sub = 1'b0; start = 1'b1;
        step();
        a = a1; b = b1; cin = c1;
        wait_done(3, lat);
        model(8, a0, b0, c0, 1'b0, es, ec, eo);
        asserts++; if (lat != 8) begin fails++; $display("FAIL b2b_latency1 got=%0d want=8", lat); end
        asserts++; if ({cout_v[3], ovf_v[3], sum_v[3]} !== {ec, eo, es})
            begin fails++; $display("FAIL b2b_result1 got=%b/%b/%h want=%b/%b/%h", cout_v[3], ovf_v[3], sum_v[3], ec, eo, es); end
        step();
        asserts++; if ({busy_v[3], done_v[3]} !== 2'b10) begin fails++; $display("FAIL b2b_accept got=%b want=10", {busy_v[3], done_v[3]}); end
        asserts++; if (sum_v[3] !== es) begin fails++; $display("FAIL b2b_hold got=%h want=%h", sum_v[3], es); end
        start = 1'b0;
        wait_done(3, lat);
        model(8, a1, b1, c1, 1'b0, es, ec, eo);
        asserts++; if (lat != 8) begin fails++; $display("FAIL b2b_latency2 got=%0d want=8", lat); end
        asserts++; if ({cout_v[3], ovf_v[3], sum_v[3]} !== {ec, eo, es})
            begin fails++; $display("FAIL b2b_result2 got=%b/%b/%h want=%b/%b/%h", cout_v[3], ovf_v[3], sum_v[3], ec, eo, es); end
        repeat (8) step();
    endtask

    task automatic test_reset_midrun();
        int lat, ndone;
        logic [15:0] es;
        logic ec, eo;
        start_op(16'h0077, 16'h0019, 1'b1, 1'b0);
        repeat (3) step();
        rst = 1'b1;
        #1;
        asserts++; if (busy_v[3] !== 1'b0) begin fails++; $display("FAIL midrst_busy got=%b want=0", busy_v[3]); end
        asserts++; if (sum_v[3] !== 16'h0) begin fails++; $display("FAIL midrst_sum got=%h want=0000", sum_v[3]); end
        #2;
        rst = 1'b0;
        ndone = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (done_v[3]) ndone++;
        end
        asserts++; if (ndone != 0) begin fails++; $display("FAIL midrst_no_done got=%0d want=0", ndone); end
        start_op(16'h00C3, 16'h0047, 1'b0, 1'b0);
        wait_done(3, lat);
        model(8, 16'h00C3, 16'h0047, 1'b0, 1'b0, es, ec, eo);
        asserts++; if (lat != 8 || {cout_v[3], ovf_v[3], sum_v[3]} !== {ec, eo, es})
            begin fails++; $display("FAIL midrst_next got=%0d:%b/%b/%h want=8:%b/%b/%h", lat, cout_v[3], ovf_v[3], sum_v[3], ec, eo, es); end
        repeat (8) step();
    endtask

`ifdef SERIAL_ADDER_SUB_EN
    task automatic test_sub();
        int lat;
        start_op(16'h0010, 16'h0020, 1'b0, 1'b1);
        wait_done(3, lat);
        asserts++; if (lat != 8 || {cout_v[3], sum_v[3]} !== {1'b0, 16'h00F0})
            begin fails++; $display("FAIL sub_borrow got=%0d:%b/%h want=8:0/00f0", lat, cout_v[3], sum_v[3]); end
        start_op(16'h0080, 16'h0001, 1'b0, 1'b1);
        wait_done(3, lat);
        asserts++; if ({ovf_v[3], sum_v[3]} !== {1'b1, 16'h007F})
            begin fails++; $display("FAIL sub_overflow got=%b/%h want=1/007f", ovf_v[3], sum_v[3]); end
        sub = 1'b0;
        repeat (8) step();
    endtask
`endif

    task automatic test_random_sweep();
        int lat[NCFG];
        int cnt[NCFG];
        logic [15:0] ra, rb, es;
        logic rc, rs, ec, eo;
        for (int it = 0; it < 40; it++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            if (it == 0) begin ra = 16'hFFFF; rb = 16'hFFFF; rc = 1'b1; end
            if (it == 1) begin ra = 16'h0000; rb = 16'h0000; rc = 1'b0; end
            for (int k = 0; k < NCFG; k++) begin lat[k] = -1; cnt[k] = 0; end
            start_op(ra, rb, rc, rs);
            for (int c = 1; c <= 18; c++) begin
                step();
                for (int k = 0; k < NCFG; k++) begin
                    if (done_v[k]) begin
                        cnt[k]++;
                        if (lat[k] < 0) lat[k] = c;
                    end
                end
            end
            for (int k = 0; k < NCFG; k++) begin
                model(cfg_w(k), ra, rb, rc, rs, es, ec, eo);
                asserts++;
                if (lat[k] != cfg_w(k) / cfg_b(k) || cnt[k] != 1)
                    begin fails++; $display("FAIL sweep_latency cfg=%0d got=%0d x%0d want=%0d x1", k, lat[k], cnt[k], cfg_w(k) / cfg_b(k)); end
                asserts++;
                if ({cout_v[k], ovf_v[k], sum_v[k]} !== {ec, eo, es})
                    begin fails++; $display("FAIL sweep_result cfg=%0d a=%h b=%h cin=%b sub=%b got=%b/%b/%h want=%b/%b/%h",
                                            k, ra, rb, rc, rs, cout_v[k], ovf_v[k], sum_v[k], ec, eo, es); end
            end
        end
        sub = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_reset_midrun();
`ifdef SERIAL_ADDER_SUB_EN
        test_sub();
`endif
        test_random_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
